scan_tick_gen: RTL and testbench

SCAN_TICK_GEN -- requirements
Module: scan_tick_gen

---
 rtl/scan_tick_gen.sv | 52 +++++
 tb/tb_scan_tick_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: NUM_CH independent programmable tick/square-wave dividers.
// Optional macro SCAN_TICK_SYNC_START_EN adds a sync_start input that phase-aligns all channels.
module scan_tick_gen #(
  parameter int CLK_FREQUENCY = 10_000_000,
  parameter int NUM_CH        = 4,
  parameter int DIV_W         = 24,
  parameter int DEFAULT_DIV   = 25_000,
  localparam int CW           = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
`ifdef SCAN_TICK_SYNC_START_EN
  input  logic              sync_start,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave
);
  if (CLK_FREQUENCY <= 0 || NUM_CH < 1 || NUM_CH > 16)
    $error("scan_tick_gen: bad parameters");
  logic sync;
`ifdef SCAN_TICK_SYNC_START_EN
  assign sync = sync_start;
`else
  assign sync = 1'b0;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div, cnt, last;
    logic sel, term, t, w;
    // Equality with an in-range index also rejects out-of-range cfg_ch.
    assign sel  = cfg_we && cfg_ch == CW'(i);
    assign last = div == '0 ? '0 : div - DIV_W'(1);
    assign term = ch_en[i] && cnt == last;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        div <= DIV_W'(DEFAULT_DIV);
        cnt <= '0;
        t   <= 1'b0;
        w   <= 1'b0;
      end else begin
        div <= sel ? cfg_div : div;
        cnt <= (sel || sync || !ch_en[i] || term) ? '0 : cnt + DIV_W'(1);
        t   <= !sel && !sync && term;
        w   <= sync ? 1'b0 : (!sel && term) ? ~w : w;
      end
    assign tick[i] = t;
    assign wave[i] = w;
  end
endmodule

// File: tb/tb_scan_tick_gen.sv
// tb_scan_tick_gen: directed checks of scan_tick_gen with NUM_CH=5 so that cfg_ch=5 is representable.
module tb_scan_tick_gen;
  localparam int N = 5;
  localparam int W = 24;
  logic clk = 1'b0, rst = 1'b0, cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [W-1:0] cfg_div = '0;
  logic [N-1:0] ch_en = '0;
  logic [N-1:0] tick, wave;
`ifdef SCAN_TICK_SYNC_START_EN
  logic sync_start = 1'b0;
`endif
  int checks = 0, failures = 0;
  scan_tick_gen #(.NUM_CH(N), .DIV_W(W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .ch_en(ch_en),
`ifdef SCAN_TICK_SYNC_START_EN
    .sync_start(sync_start),
`endif
    .tick(tick), .wave(wave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int ch, input int d);
    cfg_we = 1'b1;
    cfg_ch = ch[2:0];
    cfg_div = d[W-1:0];
  endtask
  initial begin
    int n;
    logic [15:0] v0, v2, v3, tv, wv;
    logic tz, wz;
    step;
    step;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wave", 32'(wave), 0);
    // Default divisor: tick[0] every 25000 cycles after release.
    rst = 1'b1;
    ch_en = 5'b00001;
    n = 0;
    do begin step; n++; end while (!tick[0] && n < 30000);
    chk("def_first", n, 25000);
    chk("def_wave1", 32'(wave[0]), 1);
    chk("def_others", 32'(tick[4:1]), 0);
    step;
    chk("def_one_cycle", 32'(tick[0]), 0);
    n = 1;
    do begin step; n++; end while (!tick[0] && n < 30000);
    chk("def_second", n, 25000);
    chk("def_wave0", 32'(wave[0]), 0);
    // ch3 div=5 written, then ch2 div=3 written two cycles later; ch3 phase undisturbed.
    ch_en = 5'b01101;
    wr(3, 5);
    step;
    cfg_we = 1'b0;
    v0 = '0; v2 = '0; v3 = '0;
    for (int j = 1; j <= 15; j++) begin
      if (j == 2) wr(2, 3); else cfg_we = 1'b0;
      step;
      v2[j] = tick[2];
      v3[j] = tick[3];
      v0[0] = v0[0] | tick[0];
    end
    cfg_we = 1'b0;
    chk("ch3_ticks", 32'(v3), 32'h8420);
    chk("ch2_ticks", 32'(v2), 32'h4920);
    chk("ch3_wave", 32'(wave[3]), 1);
    chk("ch2_wave", 32'(wave[2]), 0);
    chk("ch0_quiet", 32'(v0), 0);
    // div=0 behaves as 1: tick every cycle, wave toggles every cycle.
    ch_en = 5'b01111;
    wr(1, 0);
    step;
    cfg_we = 1'b0;
    tv = '0; wv = '0;
    for (int j = 0; j < 4; j++) begin
      step;
      tv[j] = tick[1];
      wv[j] = wave[1];
    end
    chk("div0_ticks", 32'(tv), 32'hf);
    chk("div0_wave", 32'(wv), 32'h5);
    // Out-of-range channel write must not touch ch1.
    wr(5, 9);
    step;
    cfg_we = 1'b0;
    chk("oor_tick_a", 32'(tick[1]), 1);
    chk("oor_wave_a", 32'(wave[1]), 1);
    step;
    chk("oor_tick_b", 32'(tick[1]), 1);
    chk("oor_wave_b", 32'(wave[1]), 0);
    // Write on ch1 terminal count wins over the tick.
    wr(1, 4);
    step;
    cfg_we = 1'b0;
    tv = '0;
    for (int j = 1; j <= 12; j++) begin
      if (j == 8) wr(1, 4); else cfg_we = 1'b0;
      step;
      tv[j] = tick[1];
      if (j == 8) chk("tc_wr_wave", 32'(wave[1]), 1);
    end
    cfg_we = 1'b0;
    chk("tc_wr_ticks", 32'(tv), 32'h1010);
    chk("tc_wr_wave_end", 32'(wave[1]), 0);
    // Asynchronous reset mid-count; a write pending under reset is discarded.
    rst = 1'b0;
    #2;
    chk("arst_tick", 32'(tick), 0);
    chk("arst_wave", 32'(wave), 0);
    wr(1, 2);
    step;
    rst = 1'b1;
    cfg_we = 1'b0;
    ch_en = '0;
    step;
    chk("post_rst_tick", 32'(tick), 0);
    // Enable drop freezes wave and kills ticks; re-enable restarts a full period.
    ch_en = 5'b00001;
    wr(0, 4);
    step;
    cfg_we = 1'b0;
    tv = '0;
    for (int j = 1; j <= 6; j++) begin step; tv[j] = tick[0]; end
    chk("en_ticks", 32'(tv), 32'h10);
    ch_en = '0;
    tz = 1'b0; wz = 1'b0;
    repeat (10) begin
      step;
      tz = tz | tick[0];
      wz = wz | !wave[0];
    end
    chk("dis_tick", 32'(tz), 0);
    chk("dis_wave_low", 32'(wz), 0);
    ch_en = 5'b00001;
    tv = '0;
    for (int j = 1; j <= 4; j++) begin step; tv[j] = tick[0]; end
    chk("reen_ticks", 32'(tv), 32'h10);
    chk("reen_wave", 32'(wave[0]), 0);
`ifdef SCAN_TICK_SYNC_START_EN
    ch_en = 5'b00011;
    wr(0, 5);
    step;
    wr(1, 7);
    step;
    cfg_we = 1'b0;
    repeat (6) step;
    chk("pre_sync_wave0", 32'(wave[0]), 1);
    sync_start = 1'b1;
    step;
    sync_start = 1'b0;
    chk("sync_wave", 32'(wave[1:0]), 0);
    chk("sync_tick", 32'(tick[1:0]), 0);
    v0 = '0; tv = '0;
    for (int j = 1; j <= 8; j++) begin step; v0[j] = tick[0]; tv[j] = tick[1]; end
    chk("sync_t0", 32'(v0[7:0]), 32'h20);
    chk("sync_t1", 32'(tv), 32'h80);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
